// File: rtl/dds_channel_scheduler.sv
// Round-robin NCO scheduler: shares one dds core between NUM_CH channels, each
// with its own phase accumulator and frame-consistent FCW, and tags dds results by channel.
module dds_channel_scheduler #(
  parameter  int unsigned NUM_CH      = 4,
  parameter  int unsigned PHASE_DW    = 16,
  parameter  int unsigned OUT_DW      = 16,
  parameter  int unsigned DDS_LATENCY = 4,
  localparam int unsigned CH_W        = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  cfg_wr_en,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [PHASE_DW-1:0]   cfg_fcw,
  input  logic                  cfg_sync,
  output logic [PHASE_DW-1:0]   dds_phase_tdata,
  output logic                  dds_phase_tvalid,
  input  logic [OUT_DW-1:0]     dds_sin_tdata,
  input  logic [OUT_DW-1:0]     dds_cos_tdata,
  input  logic                  dds_tvalid,
  output logic [2*OUT_DW-1:0]   m_axis_tdata,
  output logic [CH_W-1:0]       m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  output logic                  busy,
  output logic                  tag_err
);

  localparam int unsigned CNT_W = $clog2(DDS_LATENCY + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CH_W-1:0]       ch_ptr_q, ch_ptr_d;
  logic [CNT_W-1:0]      drain_cnt_q, drain_cnt_d;
  logic                  sync_pend_q, sync_pend_d;
  logic [PHASE_DW-1:0]   acc_q    [NUM_CH];
  logic [PHASE_DW-1:0]   acc_d    [NUM_CH];
  logic [PHASE_DW-1:0]   fcw_q    [NUM_CH];
  logic [PHASE_DW-1:0]   fcw_d    [NUM_CH];
  logic [PHASE_DW-1:0]   shadow_q [NUM_CH];
  logic [PHASE_DW-1:0]   shadow_d [NUM_CH];
  logic [PHASE_DW-1:0]   phase_q, phase_d;
  logic                  phase_vld_q, phase_vld_d;
  logic [CH_W-1:0]       issue_ch_q, issue_ch_d;
  logic                  tag_vld_q [DDS_LATENCY];
  logic                  tag_vld_d [DDS_LATENCY];
  logic [CH_W-1:0]       tag_ch_q  [DDS_LATENCY];
  logic [CH_W-1:0]       tag_ch_d  [DDS_LATENCY];
  logic [2*OUT_DW-1:0]   tdata_q, tdata_d;
  logic [CH_W-1:0]       tuser_q, tuser_d;
  logic                  tlast_q, tlast_d;
  logic                  tvalid_q, tvalid_d;
  logic                  busy_q, busy_d;
  logic                  tag_err_q, tag_err_d;

  logic                  issue_c, boundary_c, apply_sync_c;
  logic [PHASE_DW-1:0]   cur_acc_c, fcw_eff_c;

  // Next-state: FSM, per-channel accumulate/commit, issue register, tag pipe, output stage
  always_comb begin
    state_d     = state_q;
    ch_ptr_d    = ch_ptr_q;
    drain_cnt_d = drain_cnt_q;
    acc_d       = acc_q;
    fcw_d       = fcw_q;
    shadow_d    = shadow_q;
    phase_d     = phase_q;
    phase_vld_d = 1'b0;
    issue_ch_d  = issue_ch_q;
    tdata_d     = tdata_q;
    tuser_d     = tuser_q;
    tlast_d     = tlast_q;
    tvalid_d    = 1'b0;
    tag_err_d   = tag_err_q;

    issue_c      = (state_q == ST_RUN);
    boundary_c   = issue_c && (ch_ptr_q == '0);
    apply_sync_c = boundary_c && sync_pend_q;
    sync_pend_d  = (sync_pend_q && !apply_sync_c) || cfg_sync;

    // The boundary issue already uses the freshly committed FCW set
    fcw_eff_c = boundary_c ? shadow_q[ch_ptr_q] : fcw_q[ch_ptr_q];
    cur_acc_c = apply_sync_c ? '0 : acc_q[ch_ptr_q];

    if (cfg_wr_en) shadow_d[cfg_ch] = cfg_fcw;
    if (boundary_c) fcw_d = shadow_q;
    if (apply_sync_c) begin
      for (int unsigned i = 0; i < NUM_CH; i++) acc_d[i] = '0;
    end

    if (issue_c) begin
      phase_d           = cur_acc_c;
      phase_vld_d       = 1'b1;
      issue_ch_d        = ch_ptr_q;
      acc_d[ch_ptr_q]   = cur_acc_c + fcw_eff_c;
      ch_ptr_d          = (ch_ptr_q == LAST_CH) ? '0 : ch_ptr_q + CH_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if ((ch_ptr_q == LAST_CH) && !enable) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = CNT_W'(DDS_LATENCY - 1);
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) state_d = ST_IDLE;
        else drain_cnt_d = drain_cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);

    // Tag pipe is fed from the issue register so its tail lines up with dds_tvalid
    tag_vld_d[0] = phase_vld_q;
    tag_ch_d[0]  = issue_ch_q;
    for (int unsigned i = 1; i < DDS_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_ch_d[i]  = tag_ch_q[i-1];
    end

    if (dds_tvalid != tag_vld_q[DDS_LATENCY-1]) tag_err_d = 1'b1;
    if (dds_tvalid) begin
      tvalid_d = 1'b1;
      tdata_d  = {dds_sin_tdata, dds_cos_tdata};
      tuser_d  = tag_ch_q[DDS_LATENCY-1];
      tlast_d  = (tag_ch_q[DDS_LATENCY-1] == LAST_CH);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ch_ptr_q    <= '0;
      drain_cnt_q <= '0;
      sync_pend_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i]    <= '0;
        fcw_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
      issue_ch_q  <= '0;
      for (int unsigned i = 0; i < DDS_LATENCY; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_ch_q[i]  <= '0;
      end
      tdata_q     <= '0;
      tuser_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      tag_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_ptr_q    <= ch_ptr_d;
      drain_cnt_q <= drain_cnt_d;
      sync_pend_q <= sync_pend_d;
      acc_q       <= acc_d;
      fcw_q       <= fcw_d;
      shadow_q    <= shadow_d;
      phase_q     <= phase_d;
      phase_vld_q <= phase_vld_d;
      issue_ch_q  <= issue_ch_d;
      tag_vld_q   <= tag_vld_d;
      tag_ch_q    <= tag_ch_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      tvalid_q    <= tvalid_d;
      busy_q      <= busy_d;
      tag_err_q   <= tag_err_d;
    end
  end

  assign dds_phase_tdata  = phase_q;
  assign dds_phase_tvalid = phase_vld_q;
  assign m_axis_tdata     = tdata_q;
  assign m_axis_tuser     = tuser_q;
  assign m_axis_tlast     = tlast_q;
  assign m_axis_tvalid    = tvalid_q;
  assign busy             = busy_q;
  assign tag_err          = tag_err_q;

endmodule

// File: tb/tb_dds_channel_scheduler.sv
// Scoreboard bench for dds_channel_scheduler with a 4-cycle dds stand-in (sin=phase, cos=~phase).
module tb_dds_channel_scheduler;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned PHASE_DW = 16;
  localparam int unsigned OUT_DW   = 16;
  localparam int unsigned LAT      = 4;
  localparam int unsigned CH_W     = 2;

  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic                last;
    logic [PHASE_DW-1:0] ph;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                enable;
  logic                cfg_wr_en;
  logic [CH_W-1:0]     cfg_ch;
  logic [PHASE_DW-1:0] cfg_fcw;
  logic                cfg_sync;
  logic [PHASE_DW-1:0] dds_phase_tdata;
  logic                dds_phase_tvalid;
  logic [OUT_DW-1:0]   dds_sin_tdata;
  logic [OUT_DW-1:0]   dds_cos_tdata;
  logic                dds_tvalid;
  logic [2*OUT_DW-1:0] m_axis_tdata;
  logic [CH_W-1:0]     m_axis_tuser;
  logic                m_axis_tlast;
  logic                m_axis_tvalid;
  logic                busy;
  logic                tag_err;
  logic                gap;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  dds_channel_scheduler #(
    .NUM_CH(NUM_CH), .PHASE_DW(PHASE_DW), .OUT_DW(OUT_DW), .DDS_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .cfg_wr_en(cfg_wr_en), .cfg_ch(cfg_ch), .cfg_fcw(cfg_fcw), .cfg_sync(cfg_sync),
    .dds_phase_tdata(dds_phase_tdata), .dds_phase_tvalid(dds_phase_tvalid),
    .dds_sin_tdata(dds_sin_tdata), .dds_cos_tdata(dds_cos_tdata), .dds_tvalid(dds_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .busy(busy), .tag_err(tag_err)
  );

  // dds stand-in: fixed latency, trivially invertible outputs, optional valid gap
  logic [PHASE_DW-1:0] m_ph  [LAT];
  logic                m_vld [LAT];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) begin
        m_ph[i]  <= '0;
        m_vld[i] <= 1'b0;
      end
    end else begin
      m_ph[0]  <= dds_phase_tdata;
      m_vld[0] <= dds_phase_tvalid;
      for (int i = 1; i < LAT; i++) begin
        m_ph[i]  <= m_ph[i-1];
        m_vld[i] <= m_vld[i-1];
      end
    end
  end
  assign dds_sin_tdata = m_ph[LAT-1];
  assign dds_cos_tdata = ~m_ph[LAT-1];
  assign dds_tvalid    = m_vld[LAT-1] & ~gap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_one(input int ch, input logic [PHASE_DW-1:0] ph);
    exp_t e;
    e.ch   = CH_W'(ch);
    e.last = (ch == NUM_CH - 1);
    e.ph   = ph;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [PHASE_DW-1:0] p0, p1, p2, p3);
    push_one(0, p0); push_one(1, p1); push_one(2, p2); push_one(3, p3);
  endtask

  task automatic cfg_write(input int ch, input logic [PHASE_DW-1:0] val);
    @(negedge clk);
    cfg_wr_en = 1'b1; cfg_ch = CH_W'(ch); cfg_fcw = val;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  // Runs nfr frames; step k drives the inputs sampled at the k-th posedge after start.
  // lat = phase-valid to m_axis_tvalid cycles, bgap = last phase-valid to busy low cycles.
  task automatic run_sched(input int nfr, input int wr_k, input int wr_ch,
                           input logic [PHASE_DW-1:0] wr_val, input int sync_k,
                           input int gap_k, output int lat, output int bgap);
    int kphase = -1, kout = -1, klast = -1, kidle = -1;
    for (int k = 1; k <= 4 * nfr + 12; k++) begin
      @(negedge clk);
      if (dds_phase_tvalid) begin
        if (kphase < 0) kphase = k;
        klast = k;
      end
      if (m_axis_tvalid && kout < 0) kout = k;
      if (klast >= 0 && k > klast && kidle < 0 && !busy) kidle = k;
      enable    = (k <= 4 * nfr - 2);
      cfg_wr_en = (k == wr_k);
      cfg_ch    = CH_W'(wr_ch);
      cfg_fcw   = wr_val;
      cfg_sync  = (k == sync_k);
      gap       = (k == gap_k);
    end
    enable = 1'b0; cfg_wr_en = 1'b0; cfg_sync = 1'b0; gap = 1'b0;
    lat  = kout - kphase;
    bgap = kidle - klast;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("busy_idle_after_run", 64'(busy), 64'd0);
  endtask

  initial begin
    int lat, bgap;
    reset_n = 1'b0; enable = 1'b0; cfg_wr_en = 1'b0; cfg_ch = '0;
    cfg_fcw = '0; cfg_sync = 1'b0; gap = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (reset_n && m_axis_tvalid) begin
          if (exp_q.size() == 0) begin
            check("out_unexpected_queue_size", 64'(exp_q.size()), 64'd1);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_sample", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
                  64'({e.ch, e.last, e.ph, ~e.ph}));
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_phase_tvalid", 64'(dds_phase_tvalid), 64'd0);
    check("rst_phase_tdata", 64'(dds_phase_tdata), 64'd0);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_m_tuser_tlast", 64'({m_axis_tuser, m_axis_tlast}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tag_err", 64'(tag_err), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1/T2: three frames from zero phase; latency and tlast via scoreboard
    cfg_write(0, 16'h0400); cfg_write(1, 16'h0800);
    cfg_write(2, 16'h1000); cfg_write(3, 16'h4000);
    push_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    push_frame(16'h0400, 16'h0800, 16'h1000, 16'h4000);
    push_frame(16'h0800, 16'h1000, 16'h2000, 16'h8000);
    run_sched(3, 0, 0, 16'h0, 0, 0, lat, bgap);
    check("T2_issue_to_out_latency", 64'(lat), 64'd5);
    check("T1_busy_fall", 64'(bgap), 64'd4);

    // T3: enable dropped during ch1 issue, whole frame still issued (ch3 wraps)
    push_frame(16'h0C00, 16'h1800, 16'h3000, 16'hC000);
    run_sched(1, 0, 0, 16'h0, 0, 0, lat, bgap);
    check("T3_busy_fall", 64'(bgap), 64'd4);
    check("T3_latency", 64'(lat), 64'd5);

    // T4a: mid-frame FCW write on ch2 takes effect at the next frame
    push_frame(16'h1000, 16'h2000, 16'h4000, 16'h0000);
    push_frame(16'h1400, 16'h2800, 16'h5000, 16'h4000);
    push_frame(16'h1800, 16'h3000, 16'h7000, 16'h8000);
    run_sched(3, 3, 2, 16'h2000, 0, 0, lat, bgap);

    // T4b: write in the boundary cycle commits only at the following boundary
    push_frame(16'h1C00, 16'h3800, 16'h9000, 16'hC000);
    push_frame(16'h2000, 16'h4000, 16'hB000, 16'h0000);
    push_frame(16'h2400, 16'h4800, 16'hB800, 16'h4000);
    run_sched(3, 2, 2, 16'h0800, 0, 0, lat, bgap);

    // T5a: last write wins, IDLE sync zeroes at first frame, ch1 wraps, mid-run sync
    cfg_write(1, 16'h1234);
    cfg_write(1, 16'hC000);
    @(negedge clk); cfg_sync = 1'b1;
    @(negedge clk); cfg_sync = 1'b0;
    push_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    push_frame(16'h0400, 16'hC000, 16'h0800, 16'h4000);
    push_frame(16'h0800, 16'h8000, 16'h1000, 16'h8000);
    push_frame(16'h0C00, 16'h4000, 16'h1800, 16'hC000);
    push_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run_sched(5, 0, 0, 16'h0, 16, 0, lat, bgap);

    // T5b: sync coinciding with a boundary applies one frame later
    push_frame(16'h0400, 16'hC000, 16'h0800, 16'h4000);
    push_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run_sched(2, 0, 0, 16'h0, 2, 0, lat, bgap);

    // T6: asynchronous reset in the middle of a run
    @(negedge clk); enable = 1'b1;
    repeat (4) @(negedge clk);
    check("T6_pre_reset_busy", 64'(busy), 64'd1);
    check("T6_pre_reset_tvalid", 64'(dds_phase_tvalid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("T6_async_phase_tvalid", 64'(dds_phase_tvalid), 64'd0);
    check("T6_async_phase_tdata", 64'(dds_phase_tdata), 64'd0);
    check("T6_async_busy", 64'(busy), 64'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // T6: dds_tvalid gap on the first sample sets sticky tag_err; rest still forwarded
    cfg_write(0, 16'h1111);
    push_one(1, 16'h0000); push_one(2, 16'h0000); push_one(3, 16'h0000);
    push_frame(16'h1111, 16'h0000, 16'h0000, 16'h0000);
    check("T6_tag_err_before_gap", 64'(tag_err), 64'd0);
    run_sched(2, 0, 0, 16'h0, 0, 7, lat, bgap);
    check("T6_tag_err_set", 64'(tag_err), 64'd1);
    repeat (10) @(negedge clk);
    check("T6_tag_err_sticky", 64'(tag_err), 64'd1);
    reset_n = 1'b0;
    #1;
    check("T6_tag_err_reset", 64'(tag_err), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
